e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Parametrised multiply/divide unit in the E stage of the 5-stage pipeline, beside E_ALU.
- Owns the HI/LO registers.
- Executes mult/multu/div/divu/madd/maddu/msub/msubu with configurable latency, and mthi/mtlo in a single cycle.
- Drives a busy/hazard signal so the stall controller holds D for md-class instructions.
- Supports cancel of an in-flight operation, for exception flush.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage md instruction valid this cycle
op  input  4  operation code (mdu_pkg)
data1  input  WIDTH  forwarded rs value
data2  input  WIDTH  forwarded rt value
cancel  input  1  abort in-flight op and block this cycle's start
busy  output  1  registered; operation in flight
md_hazard  output  1  combinational: busy | (start & op is multi-cycle)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result=0. Takes effect immediately, including mid-operation.
- Op codes:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU.
  - 11-15 treated as NONE.
- Accepted start: start=1 & busy=0 & cancel=0. Any other start is ignored, with no state change; the controller must stall on md_hazard.
- MTHI/MTLO: on an accepted edge, hi<=data1 or lo<=data1. busy stays 0. The new value is visible the next cycle.
- Multi-cycle ops on an accepted edge:
  - The 2*WIDTH result is computed from data1/data2 and the current {hi,lo}, and latched into pending.
  - Counter loads MULT_CYCLES or DIV_CYCLES. busy=1 from the next cycle.
- Counting: counter decrements each edge while non-zero. On the edge where counter goes 1->0, {hi,lo}<=pending and busy<=0. busy is high exactly N cycles, and hi/lo update in the same cycle busy falls.
- Arithmetic:
  - MULT: signed full product, {hi,lo}. MULTU: unsigned.
  - MADD/MSUB: {hi,lo} ± signed product, modulo 2^(2*WIDTH). MADDU/MSUBU: unsigned product, same wrap.
  - DIV: lo=quotient truncated toward zero; hi=remainder, sign of dividend. DIVU: unsigned.
  - Divide by zero: lo=all ones, hi=data1.
  - Signed overflow (MIN / -1): lo=MIN, hi=0.
- Cancel:
  - cancel=1 clears counter and busy at the next edge; pending is discarded and hi/lo stay unchanged.
  - If the counter is at 1 on the cancel edge, cancel wins: no commit.
- md_hazard is combinational so the D stage stalls in the same cycle a multi-cycle op enters E.
- mfhi/mflo read hi/lo directly. The controller stalls them while md_hazard=1.

Decomposition:
- mdu_pkg holds:
  - op code localparams (MDU_NONE..MDU_MSUBU);
  - helper function is_multi(op);
  - width defaults.
- Sub-module mdu_arith: purely combinational, producing the 2*WIDTH result from op, data1, data2, hi, lo. It contains the signed/unsigned, div-by-zero and overflow rules.
- e_mdu keeps only the counter, pending register, HI/LO and handshake logic.

Test Plan:
1. Reset asserted low mid-run -> hi=0, lo=0, busy=0 immediately, without waiting for a clock edge. After release, md_hazard=0 with start=0.
2. MULT of 0xFFFFFFFF × 0x00000002 -> md_hazard=1 in the start cycle, then busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. The same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
3. Division cases:
   - DIV of 0xFFFFFFF9 / 0x00000002 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU of 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
   - DIV of 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTLO 0xFFFFFFFF, then MTHI 0, then MADDU 1×1 -> hi=0x00000001, lo=0x00000000 after 5 cycles. MSUB 1×1 from {0,0} -> hi=lo=0xFFFFFFFF.
5. MULT started, then a second MULT (different operands) pulsed while busy -> the second is ignored, busy totals 5 cycles, and hi/lo hold only the first result.
6. DIV started with cancel=1 on busy cycle 4 -> busy=0 next cycle and hi/lo unchanged. Also cancel=1 on the final counting cycle (counter=1) -> no commit. A start with cancel=1 in the same cycle -> not accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, default sizes
// and op classification helpers.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH       = 32;
    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    // Ops that occupy the unit for several cycles and stall the D stage.
    function automatic logic is_multi(input logic [3:0] op);
        logic res;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: res = 1'b1;
            default:                                  res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: forms the {hi,lo} result of a multi-cycle op
// from the operands and the current HI/LO contents.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;
    logic [WIDTH-1:0]   min_val;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               div_signed;
    logic               div_zero;
    logic               div_ovf;
    logic               neg1;
    logic               neg2;

    assign acc   = {hi, lo};
    assign sprod = $signed({{WIDTH{data1[WIDTH-1]}}, data1})
                 * $signed({{WIDTH{data2[WIDTH-1]}}, data2});
    assign uprod = {{WIDTH{1'b0}}, data1} * {{WIDTH{1'b0}}, data2};

    // One unsigned divider serves both DIV and DIVU; signed ops divide magnitudes.
    assign div_signed = (op == MDU_DIV);
    assign neg1       = div_signed & data1[WIDTH-1];
    assign neg2       = div_signed & data2[WIDTH-1];
    assign dvd        = neg1 ? -data1 : data1;
    assign dvs        = neg2 ? -data2 : data2;
    assign div_zero   = (data2 == '0);
    assign quo        = div_zero ? '0 : dvd / dvs;
    assign rem        = div_zero ? '0 : dvd % dvs;
    assign quo_s      = (neg1 ^ neg2) ? -quo : quo;
    assign rem_s      = neg1 ? -rem : rem;
    assign min_val    = {1'b1, {(WIDTH-1){1'b0}}};
    assign div_ovf    = div_signed && (data1 == min_val) && (data2 == {WIDTH{1'b1}});

    always_comb begin
        result = '0;
        case (op)
            MDU_MULT:  result = sprod;
            MDU_MULTU: result = uprod;
            MDU_MADD:  result = acc + sprod;
            MDU_MADDU: result = acc + uprod;
            MDU_MSUB:  result = acc - sprod;
            MDU_MSUBU: result = acc - uprod;
            MDU_DIV, MDU_DIVU: begin
                if (div_zero) begin
                    result = {data1, {WIDTH{1'b1}}};
                end else if (div_ovf) begin
                    result = {{WIDTH{1'b0}}, min_val};
                end else begin
                    result = {rem_s, quo_s};
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs md ops with fixed latency and
// raises md_hazard so the stall controller can hold the D stage.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = MDU_WIDTH,
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             cancel,
    output logic             busy,
    output logic             md_hazard,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [2*WIDTH-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   result;
    logic                 accept;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (op),
        .data1  (data1),
        .data2  (data2),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (result)
    );

    assign accept    = start & ~busy_q & ~cancel;
    assign md_hazard = busy_q | (start & is_multi(op));
    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        // Cancel outranks both the final commit and a same-cycle start.
        if (cancel) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            pend_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntWidth'(1);
            if (cnt_q == CntWidth'(1)) begin
                busy_d       = 1'b0;
                {hi_d, lo_d} = pend_q;
            end
        end else if (accept) begin
            if (op == MDU_MTHI) begin
                hi_d = data1;
            end else if (op == MDU_MTLO) begin
                lo_d = data1;
            end else if (is_multi(op)) begin
                pend_d = result;
                busy_d = 1'b1;
                cnt_d  = is_div(op) ? CntWidth'(DIV_CYCLES) : CntWidth'(MULT_CYCLES);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed cases plus random ops checked against an arithmetic
// reference model of HI/LO.
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        cancel;
    logic        busy;
    logic        md_hazard;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu #(
        .WIDTH       (32),
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .data1     (data1),
        .data2     (data2),
        .cancel    (cancel),
        .busy      (busy),
        .md_hazard (md_hazard),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_multi(input logic [3:0] o);
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
    endfunction

    function automatic int ref_cycles(input logic [3:0] o);
        return (o == 4'd3 || o == 4'd4) ? DIV_N : MULT_N;
    endfunction

    // Plain 64-bit arithmetic view of what {hi,lo} becomes after an op.
    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint      sa, sb;
        logic [63:0] acc, sp, up, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {h, l};
        sp  = sa * sb;
        up  = {32'd0, a} * {32'd0, b};
        case (o)
            4'd1:  return sp;
            4'd2:  return up;
            4'd7:  return acc + sp;
            4'd8:  return acc + up;
            4'd9:  return acc - sp;
            4'd10: return acc - up;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd5:  return {a, l};
            4'd6:  return {h, a};
            default: return {h, l};
        endcase
    endfunction

    // Issue one op from idle, check hazard, latency and final HI/LO.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          n;
        exp = ref_result(o, a, b, m_hi, m_lo);
        @(negedge clk);
        op = o; data1 = a; data2 = b; start = 1'b1;
        #1 check("hazard", {63'd0, md_hazard}, {63'd0, ref_multi(o)});
        @(posedge clk);
        #1 start = 1'b0;
        if (ref_multi(o)) begin
            check("hold_during_busy", {hi, lo}, {m_hi, m_lo});
            n = 0;
            while (busy && n < 200) begin
                n++;
                @(posedge clk);
                #1;
            end
            check("busy_cycles", 64'(n), 64'(ref_cycles(o)));
        end else begin
            check("busy_single", {63'd0, busy}, 64'd0);
        end
        {m_hi, m_lo} = exp;
        check("hi", {32'd0, hi}, {32'd0, m_hi});
        check("lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = 4'd0; data1 = '0; data2 = '0; cancel = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", {30'd0, busy, md_hazard, hi, lo}, 64'd0);
        @(negedge clk) reset = 1'b1;

        // Multiply: signed and unsigned views of the same operands.
        run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // Division rules.
        run_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd4, 32'd7, 32'd0);
        check("divu_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        // Accumulating forms with carry/borrow across LO/HI.
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd5, 32'd0, 32'd0);
        run_op(4'd8, 32'd1, 32'd1);
        check("maddu_carry", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op(4'd5, 32'd0, 32'd0);
        run_op(4'd6, 32'd0, 32'd0);
        run_op(4'd9, 32'd1, 32'd1);
        check("msub_borrow", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Second start while busy is ignored.
        @(negedge clk);
        op = 4'd1; data1 = 32'd3; data2 = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        @(posedge clk);
        #1 n++;
        @(negedge clk);
        op = 4'd2; data1 = 32'd100; data2 = 32'd100; start = 1'b1;
        #1 check("hazard_while_busy", {63'd0, md_hazard}, 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        n++;
        while (busy && n < 200) begin
            @(posedge clk);
            #1 if (busy) n++;
        end
        check("busy_with_ignored", 64'(n), 64'(MULT_N));
        m_hi = 32'd0; m_lo = 32'd12;
        check("ignored_result", {hi, lo}, {m_hi, m_lo});

        // Cancel on busy cycle 4.
        @(negedge clk);
        op = 4'd3; data1 = 32'd50; data2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk) cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_mid_busy", {63'd0, busy}, 64'd0);
        repeat (DIV_N + 2) @(posedge clk);
        #1 check("cancel_mid_hilo", {hi, lo}, {m_hi, m_lo});

        // Cancel when the counter is at 1.
        @(negedge clk);
        op = 4'd4; data1 = 32'd99; data2 = 32'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (DIV_N - 1) begin
            @(posedge clk);
            #1;
        end
        check("still_busy_last", {63'd0, busy}, 64'd1);
        @(negedge clk) cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_last_busy", {63'd0, busy}, 64'd0);
        check("cancel_last_hilo", {hi, lo}, {m_hi, m_lo});

        // Start with cancel in the same cycle is not accepted.
        @(negedge clk);
        op = 4'd1; data1 = 32'd9; data2 = 32'd9; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        check("start_cancel_busy", {63'd0, busy}, 64'd0);
        repeat (MULT_N + 1) @(posedge clk);
        #1 check("start_cancel_hilo", {hi, lo}, {m_hi, m_lo});

        // Random ops against the model.
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), pick_data(), pick_data());
        end

        // Reset mid-operation clears state without a clock edge.
        if (hi == 32'd0 && lo == 32'd0) run_op(4'd6, 32'h1234_5678, 32'd0);
        @(negedge clk);
        op = 4'd1; data1 = 32'd5; data2 = 32'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #2 reset = 1'b0;
        #1 check("async_reset", {31'd0, busy, hi, lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk) reset = 1'b1;
        #1 check("hazard_after_reset", {63'd0, md_hazard}, 64'd0);
        run_op(4'd2, 32'd7, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
